// File: rtl/seg7_pkg.sv
// Seven-segment helpers shared by the board-level test builds.
// Segment byte layout is {a,b,c,d,e,f,g,dp}, active-high.
package seg7_pkg;

    localparam logic [7:0] SEG7_0     = 8'b11111100;
    localparam logic [7:0] SEG7_1     = 8'b01100000;
    localparam logic [7:0] SEG7_2     = 8'b11011010;
    localparam logic [7:0] SEG7_3     = 8'b11110010;
    localparam logic [7:0] SEG7_4     = 8'b01100110;
    localparam logic [7:0] SEG7_5     = 8'b10110110;
    localparam logic [7:0] SEG7_6     = 8'b10111110;
    localparam logic [7:0] SEG7_7     = 8'b11100000;
    localparam logic [7:0] SEG7_8     = 8'b11111110;
    localparam logic [7:0] SEG7_9     = 8'b11110110;
    localparam logic [7:0] SEG7_A     = 8'b11101110;
    localparam logic [7:0] SEG7_B     = 8'b00111110;
    localparam logic [7:0] SEG7_C     = 8'b00011010;
    localparam logic [7:0] SEG7_D     = 8'b01111010;
    localparam logic [7:0] SEG7_E     = 8'b10011110;
    localparam logic [7:0] SEG7_F     = 8'b10001110;
    localparam logic [7:0] SEG7_BLANK = 8'b00000000;
    localparam logic [7:0] SEG7_DP    = 8'b00000001;

    // Hex nibble to segment pattern (dp clear).
    function automatic logic [7:0] seg7_hex(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = SEG7_0;
            4'h1:    seg = SEG7_1;
            4'h2:    seg = SEG7_2;
            4'h3:    seg = SEG7_3;
            4'h4:    seg = SEG7_4;
            4'h5:    seg = SEG7_5;
            4'h6:    seg = SEG7_6;
            4'h7:    seg = SEG7_7;
            4'h8:    seg = SEG7_8;
            4'h9:    seg = SEG7_9;
            4'hA:    seg = SEG7_A;
            4'hB:    seg = SEG7_B;
            4'hC:    seg = SEG7_C;
            4'hD:    seg = SEG7_D;
            4'hE:    seg = SEG7_E;
            default: seg = SEG7_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, optional debounce filter and
// falling-edge press pulse. Debounce is built only when SEG7_PROBE_DEBOUNCE_EN
// is defined; otherwise the conditioned level is the synchronised level.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic level_o,
    output logic press_o
);

`ifdef SEG7_PROBE_DEBOUNCE_EN
    localparam bit UseDebounce = 1'b1;
`else
    localparam bit UseDebounce = 1'b0;
`endif

    logic [1:0] sync_q;
    logic       level;
    logic       level_prev_q;

    // Two-stage synchroniser; idles high like the released button.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_ni};
        end
    end

    if (UseDebounce) begin : g_debounce
        localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (sync_q[1] != lvl_q) begin
                if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounce state.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                lvl_q <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level = lvl_q;
    end else begin : g_direct
        assign level = sync_q[1];
    end

    // Previous conditioned level, for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_prev_q <= 1'b1;
        end else begin
            level_prev_q <= level;
        end
    end

    assign level_o = level;
    assign press_o = level_prev_q & ~level;

endmodule

// File: rtl/seg7_probe_display.sv
// Multi-channel probe display: a button steps through CHANNELS probe buses,
// a hold switch freezes the sample, and DIGITS seven-segment digits show the
// channel index (digit 0, dp = holding) and the sample in hex (digits 1..).
// Optional debounce on both buttons: define SEG7_PROBE_DEBOUNCE_EN.
module seg7_probe_display
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS          = 8,
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [CHANNELS*WIDTH-1:0]                           probe_i,
    input  logic                                                next_n_i,
    input  logic                                                hold_n_i,
    output logic [8*DIGITS-1:0]                                 display_o,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  channel_o,
    output logic                                                update_o,
    output logic                                                selecter_o
);

    localparam int unsigned ChanW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned ExtW   = 4 * (DIGITS - 1);
    localparam int unsigned NumNib = (WIDTH + 3) / 4;

    logic             next_press, next_level;
    logic             hold_press, hold_level;
    logic             hold;
    logic             unused_btn;

    logic [ChanW-1:0] channel_q, channel_d;
    logic             chan_changed_q;
    logic [WIDTH-1:0] sel_value;
    logic [WIDTH-1:0] captured_q, captured_d;
    logic             load;
    logic             update_q;
    logic [ExtW-1:0]  cap_ext;
    logic [8*DIGITS-1:0] display_q, display_d;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_ni  (next_n_i),
        .level_o (next_level),
        .press_o (next_press)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_ni  (hold_n_i),
        .level_o (hold_level),
        .press_o (hold_press)
    );

    assign unused_btn = next_level ^ hold_press;
    assign hold       = ~hold_level;

    // Channel mux, next channel and sample load decision.
    always_comb begin
        sel_value = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (channel_q == ChanW'(c)) begin
                sel_value = probe_i[c*WIDTH +: WIDTH];
            end
        end

        channel_d = channel_q;
        if (next_press) begin
            channel_d = (channel_q == ChanW'(CHANNELS - 1)) ? '0 : channel_q + 1'b1;
        end

        // A fresh channel is sampled once even while holding.
        load       = ~hold | chan_changed_q;
        captured_d = load ? sel_value : captured_q;
    end

    // Channel, sample and change-pulse state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            channel_q      <= '0;
            chan_changed_q <= 1'b0;
            captured_q     <= '0;
            update_q       <= 1'b0;
        end else begin
            channel_q      <= channel_d;
            chan_changed_q <= (channel_d != channel_q);
            captured_q     <= captured_d;
            update_q       <= (captured_d != captured_q);
        end
    end

    // Display image: channel + hold dp on digit 0, sample nibbles above, blanks beyond.
    always_comb begin
        cap_ext              = '0;
        cap_ext[WIDTH-1:0]   = captured_q;
        display_d            = '0;
        display_d[7:0]       = seg7_hex(4'(channel_q)) | (hold ? SEG7_DP : SEG7_BLANK);
        for (int unsigned k = 1; k < DIGITS; k++) begin
            if (k <= NumNib) begin
                display_d[8*k +: 8] = seg7_hex(cap_ext[4*(k-1) +: 4]);
            end else begin
                display_d[8*k +: 8] = SEG7_BLANK;
            end
        end
    end

    // Registered display image; blank during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            display_q <= '0;
        end else begin
            display_q <= display_d;
        end
    end

    assign display_o  = display_q;
    assign channel_o  = channel_q;
    assign update_o   = update_q;
    assign selecter_o = 1'b1;

endmodule
